// File: rtl/lifo_stack.sv
// LIFO stack with a registered top-of-stack. data_out shows the current top
// (show-ahead), so a pop can use the value in the same cycle it is requested.
// Entries below the top are held in a (DEPTH-1)-entry array indexed by occupancy.
//
// Build option: define LIFO_STACK_STICKY_ERR_EN to make overflow_err and
// underflow_err sticky. Once set they stay high until resetN or clear.
// Without the macro they are single-cycle pulses.
module lifo_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned IdxW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [PTR_W-1:0] DepthCnt = PTR_W'(DEPTH);

  logic [PTR_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Storage for every entry below the top.
  logic [WIDTH-1:0] mem_q [DEPTH-1];
  logic             mem_we;
  logic [IdxW-1:0]  wr_idx;
  logic [IdxW-1:0]  rd_idx;

  // A push stores the old top at slot count-1. A pop brings back the entry
  // directly below the top, which is at slot count-2.
  assign wr_idx = IdxW'(count_q - PTR_W'(1));
  assign rd_idx = IdxW'(count_q - PTR_W'(2));

  // Next-state decode. Exactly one action is applied per edge, in priority order.
  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    mem_we  = 1'b0;
`ifdef LIFO_STACK_STICKY_ERR_EN
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`else
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
`endif
    if (clear) begin
      // The flush also wins over a request that would otherwise raise an error.
      count_d = '0;
      tos_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push && pop) begin
      tos_d = data_in;
      if (count_q == '0) begin
        // Nothing to pop: the push is still taken, and the pop is flagged.
        count_d = PTR_W'(1);
        unf_d   = 1'b1;
      end
    end else if (push) begin
      if (count_q == DepthCnt) begin
        ovf_d = 1'b1;
      end else begin
        mem_we  = (count_q != '0);
        tos_d   = data_in;
        count_d = count_q + PTR_W'(1);
      end
    end else if (pop) begin
      if (count_q == '0) begin
        unf_d = 1'b1;
      end else if (count_q == PTR_W'(1)) begin
        tos_d   = '0;
        count_d = '0;
      end else begin
        tos_d   = mem_q[rd_idx];
        count_d = count_q - PTR_W'(1);
      end
    end
  end

  // State registers. Asynchronous reset returns the stack to empty.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      tos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Array write. The contents are not reset, because count decides which slots are valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= tos_q;
    end
  end

  // The outputs come directly from registers or from a decode of the registered count.
  always_comb begin
    data_out      = tos_q;
    full          = (count_q == DepthCnt);
    empty         = (count_q == '0);
    overflow_err  = ovf_q;
    underflow_err = unf_q;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack. A queue-based reference stack predicts
// the outputs for each driven cycle. The predictions are queued and then checked after the edge.
module tb_lifo_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic             clk;
  logic             resetN;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (5)
  ) u_dut (
    .clk           (clk),
    .resetN        (resetN),
    .push          (push),
    .pop           (pop),
    .clear         (clear),
    .data_in       (data_in),
    .data_out      (data_out),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] stk[$];
  logic             ovf_m;
  logic             unf_m;
  int               n_checks;
  int               n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_top();
    if (stk.size() == 0) return '0;
    return stk[stk.size()-1];
  endfunction

  // Reference model: apply one cycle of requests, then predict the outputs.
  task automatic model_apply(input logic p, input logic o, input logic c,
                             input logic [WIDTH-1:0] din);
    exp_t e;
`ifndef LIFO_STACK_STICKY_ERR_EN
    ovf_m = 1'b0;
    unf_m = 1'b0;
`endif
    if (c) begin
      stk.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else if (p && o) begin
      if (stk.size() > 0) begin
        stk[stk.size()-1] = din;
      end else begin
        stk.push_back(din);
        unf_m = 1'b1;
      end
    end else if (p) begin
      if (stk.size() < DEPTH) stk.push_back(din);
      else ovf_m = 1'b1;
    end else if (o) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else unf_m = 1'b1;
    end
    e.d     = model_top();
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.ovf   = ovf_m;
    e.unf   = unf_m;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underrun", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("data_out", 32'(data_out), 32'(e.d));
      check_eq("full", 32'(full), 32'(e.full));
      check_eq("empty", 32'(empty), 32'(e.empty));
      check_eq("overflow_err", 32'(overflow_err), 32'(e.ovf));
      check_eq("underflow_err", 32'(underflow_err), 32'(e.unf));
    end
  endtask

  // Drive one cycle of requests. Before the edge, check the show-ahead top.
  // After the edge, check the outputs against the scoreboard.
  task automatic step(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] din);
    push    = p;
    pop     = o;
    clear   = c;
    data_in = din;
    #1;
    check_eq("tos_before_edge", 32'(data_out), 32'(model_top()));
    model_apply(p, o, c, din);
    @(posedge clk);
    #1;
    compare_out();
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_empty"}, 32'(empty), 32'd1);
    check_eq({tag, "_full"}, 32'(full), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    check_eq({tag, "_unf"}, 32'(underflow_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
    resetN   = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    data_in  = '0;
    #12;
    check_reset_vals("reset");
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Push three words. Each one should be visible on data_out after its edge.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    // Hold pop for two cycles. The value shown before each edge is the one removed.
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    // Bring count back to 2 with 0x22 on top, then push and pop together to replace the top.
    step(1, 0, 0, 8'h22);
    step(1, 1, 0, 8'h7F);
    step(0, 0, 1, 8'h00);

    // Fill to DEPTH, try to overflow once, then idle for a cycle.
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'hAA);
    step(0, 0, 0, 8'h00);
    // Drain everything to confirm LIFO order through the array.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // Pop from empty, then push and pop together on an empty stack.
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h05);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // Assert clear together with a push at count 3.
    step(1, 0, 0, 8'hA1);
    step(1, 0, 0, 8'hA2);
    step(1, 0, 0, 8'hA3);
    step(1, 0, 1, 8'hA4);

    // Drop the asynchronous reset in the middle of a push cycle.
    step(1, 0, 0, 8'hB1);
    step(1, 0, 0, 8'hB2);
    push    = 1'b1;
    data_in = 8'h99;
    #3;
    resetN = 1'b0;
    #1;
    check_reset_vals("async_reset");
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(negedge clk);
    push   = 1'b0;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 8'h44);
    step(0, 1, 0, 8'h00);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
